sync_frame_tx: RTL and testbench

Serial frame transmitter for the team's non-overlapping "1010" Mealy sequence detector. It sits upstream of that receiver on the same one-bit line. Each accepted payload word is sent as the fixed sync word 1010, then the payload MSB-first. The payload region is bit-stuffed so that the pattern 1010 never appears anywhere except in the sync word, including across frame boundaries and into idle.

---
 rtl/sync_frame_tx.sv | 180 ++++++++++++++++++
 tb/tb_sync_frame_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter feeding a non-overlapping "1010"
// detector. Each frame is the sync word 1010 followed by the payload MSB-first.
// The payload region is bit-stuffed so 1010 never appears outside the sync word.
// Optional feature macro: SYNC_FRAME_PARITY_EN (appends an even-parity bit).
//
// Every output is registered. Each rising edge decides the bit that tx_out
// carries during the following cycle. A frame therefore starts on the line
// in the cycle right after the accept edge.
module sync_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              stuff_out
);

`ifdef SYNC_FRAME_PARITY_EN
  localparam int NBITS = DATA_W + 1;  // payload bits plus one parity bit
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, TAIL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        gap_q, gap_d;        // idle 0 cycles emitted, saturates at 2
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        hist_q, hist_d;      // last three emitted payload-region bits
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              stuff_q, stuff_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              next_bit;
`ifdef SYNC_FRAME_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign accept = data_valid & ready_q;

  // Next payload-region bit when no stuff is due: payload MSB, or parity last.
  always_comb begin
    next_bit = shreg_q[DATA_W-1];
`ifdef SYNC_FRAME_PARITY_EN
    if (bit_cnt_q == CNT_W'(DATA_W)) begin
      next_bit = parity_q;
    end
`endif
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    sync_cnt_d = sync_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    hist_d     = hist_q;
    shreg_d    = shreg_q;
    tx_d       = 1'b0;
    busy_d     = 1'b0;
    stuff_d    = 1'b0;
    ready_d    = 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Latch the payload and put the first sync bit on the line now.
          shreg_d    = data_in;
`ifdef SYNC_FRAME_PARITY_EN
          parity_d   = ^data_in;
`endif
          bit_cnt_d  = '0;
          hist_d     = 3'b000;
          sync_cnt_d = 2'd1;
          gap_d      = 2'd0;
          tx_d       = 1'b1;
          busy_d     = 1'b1;
          state_d    = SYNC;
        end else begin
          gap_d   = (gap_q == 2'd2) ? 2'd2 : gap_q + 2'd1;
          ready_d = (gap_d == 2'd2);
        end
      end
      SYNC: begin
        // Sync indices 1..3 carry 0, 1, 0.
        busy_d     = 1'b1;
        tx_d       = ~sync_cnt_q[0];
        sync_cnt_d = sync_cnt_q + 2'd1;
        if (sync_cnt_q == 2'd3) begin
          hist_d    = 3'b000;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        busy_d = 1'b1;
        if (hist_q == 3'b101) begin
          // A 0 here would complete 1010; insert a 1 instead. Leaves hist=011.
          tx_d    = 1'b1;
          stuff_d = 1'b1;
          hist_d  = {hist_q[1:0], 1'b1};
        end else begin
          tx_d      = next_bit;
          hist_d    = {hist_q[1:0], next_bit};
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        state_d = IDLE;
        if (hist_q == 3'b101) begin
          // A trailing 101 followed by idle 0 would look like sync.
          tx_d    = 1'b1;
          stuff_d = 1'b1;
          busy_d  = 1'b1;
          gap_d   = 2'd0;
        end else begin
          // This edge already emits the first idle 0.
          gap_d = 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = 2'd0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_q      <= 2'd0;
      sync_cnt_q <= 2'd0;
      bit_cnt_q  <= '0;
      hist_q     <= 3'b000;
      shreg_q    <= '0;
      tx_q       <= 1'b0;
      busy_q     <= 1'b0;
      stuff_q    <= 1'b0;
      ready_q    <= 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      sync_cnt_q <= sync_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hist_q     <= hist_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      stuff_q    <= stuff_d;
      ready_q    <= ready_d;
`ifdef SYNC_FRAME_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign data_ready = ready_q;
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign stuff_out  = stuff_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Testbench for sync_frame_tx: table of directed payloads with hand-computed
// frames, plus sequences for reset, inter-frame gap, mid-frame reset and a
// loopback through a behavioural non-overlapping "1010" Mealy detector.
`timescale 1ns/1ps
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic       tx_out;
  logic       busy;
  logic       stuff_out;

  always #5 clk = ~clk;

  sync_frame_tx #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .stuff_out  (stuff_out)
  );

`ifdef SYNC_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // Payload region (after the sync word), right-aligned, first bit is MSB.
  typedef struct packed {
    logic [7:0]  data;
    logic [4:0]  rlen;
    logic [15:0] rbits;
    logic [15:0] rstuff;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Present a payload, wait (bounded) for the frame, capture it while busy.
  // idle_w returns how many busy-low cycles were waited before the frame.
  task automatic send_frame(input logic [7:0] d, input bit keep,
                            output logic [31:0] bits, output logic [31:0] stf,
                            output int len, output int idle_w);
    logic prev_acc;
    int   nz;
    bits = '0; stf = '0; len = 0; idle_w = 0; nz = 0;
    data_in    = d;
    data_valid = 1'b1;
    prev_acc   = 1'b0;
    while (!busy && idle_w < 40) begin
      if (tx_out) nz++;
      prev_acc = data_ready & data_valid;
      @(negedge clk);
      idle_w++;
    end
    if (!busy) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: busy=0, required 1");
      data_valid = 1'b0;
      return;
    end
    n_vec++;
    if (!prev_acc || nz != 0) begin
      n_bad++;
      $display("FAIL accept_latency: accept_before=%0d idle_ones=%0d, required 1 and 0", prev_acc, nz);
    end
    if (!keep) data_valid = 1'b0;
    data_in = ~d;
    while (busy && len < 32) begin
      bits = {bits[30:0], tx_out};
      stf  = {stf[30:0], stuff_out};
      len++;
      @(negedge clk);
    end
  endtask

  // Behavioural non-overlapping 1010 Mealy detector on the serial line.
  logic [1:0] det_s;
  int det_all  = 0;
  int det_good = 0;
  int frame_ix = 0;
  always @(negedge clk) begin
    if (reset) begin
      det_s    <= 2'd0;
      frame_ix <= 0;
    end else begin
      if (det_s == 2'd3 && !tx_out) begin
        det_all <= det_all + 1;
        if (busy && frame_ix == 3) det_good <= det_good + 1;
      end
      case (det_s)
        2'd0: det_s <= tx_out ? 2'd1 : 2'd0;
        2'd1: det_s <= tx_out ? 2'd1 : 2'd2;
        2'd2: det_s <= tx_out ? 2'd3 : 2'd0;
        default: det_s <= tx_out ? 2'd1 : 2'd0;
      endcase
      frame_ix <= busy ? frame_ix + 1 : 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bits, stf, exp_bits;
    int len, w, a0, g0;
    logic [7:0] d;

`ifdef SYNC_FRAME_PARITY_EN
    vecs[0] = '{8'h00, 5'd9,  16'b000000000,    16'b000000000};
    vecs[1] = '{8'hA5, 5'd11, 16'b10110010110,  16'b00010000010};
    vecs[2] = '{8'hFF, 5'd9,  16'b111111110,    16'b000000000};
    vecs[3] = '{8'h0A, 5'd10, 16'b0000101100,   16'b0000000100};
    vecs[4] = '{8'h05, 5'd10, 16'b0000010110,   16'b0000000100};
    vecs[5] = '{8'hAA, 5'd12, 16'b101101101100, 16'b000100100100};
`else
    vecs[0] = '{8'h00, 5'd8,  16'b00000000,     16'b00000000};
    vecs[1] = '{8'hA5, 5'd10, 16'b1011001011,   16'b0001000001};
    vecs[2] = '{8'hFF, 5'd8,  16'b11111111,     16'b00000000};
    vecs[3] = '{8'h0A, 5'd9,  16'b000010110,    16'b000000010};
    vecs[4] = '{8'h05, 5'd9,  16'b000001011,    16'b000000001};
    vecs[5] = '{8'hAA, 5'd11, 16'b10110110110,  16'b00010010010};
`endif

    // Reset state and data_ready rising on the 2nd edge after release.
    reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'b0, tx_out}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stuff", {31'b0, stuff_out}, 32'd0);
    chk("reset_ready", {31'b0, data_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_edge1", {31'b0, data_ready}, 32'd0);
    @(negedge clk);
    chk("ready_edge2", {31'b0, data_ready}, 32'd1);

    // 8'h00 with data_valid held high; ready back in the 2nd idle cycle.
    send_frame(8'h00, 1'b1, bits, stf, len, w);
    data_valid = 1'b0;
    chk("hold00_len", len, 12 + PAR);
    chk("hold00_bits", bits, 32'hA << (8 + PAR));
    chk("hold00_stuff", stf, 32'd0);
    chk("hold00_idle1_ready", {31'b0, data_ready}, 32'd0);
    @(negedge clk);
    chk("hold00_idle2_ready", {31'b0, data_ready}, 32'd1);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, 1'b0, bits, stf, len, w);
      exp_bits = (32'hA << vecs[i].rlen) | {16'b0, vecs[i].rbits};
      chk($sformatf("vec%0d_%02h_len", i, vecs[i].data), len, 4 + 32'(vecs[i].rlen));
      chk($sformatf("vec%0d_%02h_bits", i, vecs[i].data), bits, exp_bits);
      chk($sformatf("vec%0d_%02h_stuff", i, vecs[i].data), stf, {16'b0, vecs[i].rstuff});
    end

    // Back-to-back FF then 0A with valid high: exactly 2 idle zeros between.
    send_frame(8'hFF, 1'b1, bits, stf, len, w);
    chk("b2b_ff_bits", bits, (32'hA << vecs[2].rlen) | {16'b0, vecs[2].rbits});
    send_frame(8'h0A, 1'b0, bits, stf, len, w);
    chk("b2b_gap", w, 2);
    chk("b2b_0a_bits", bits, (32'hA << vecs[3].rlen) | {16'b0, vecs[3].rbits});
    chk("b2b_0a_stuff", stf, {16'b0, vecs[3].rstuff});

    // Reset during the 6th bit of an A5 frame.
    repeat (3) @(negedge clk);
    data_in = 8'hA5; data_valid = 1'b1;
    w = 0;
    while (!busy && w < 40) begin @(negedge clk); w++; end
    chk("mid_started", {31'b0, busy}, 32'd1);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_tx", {31'b0, tx_out}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_stuff", {31'b0, stuff_out}, 32'd0);
    chk("mid_ready0", {31'b0, data_ready}, 32'd0);
    @(negedge clk);
    chk("mid_ready1", {31'b0, data_ready}, 32'd0);
    @(negedge clk);
    chk("mid_ready2", {31'b0, data_ready}, 32'd1);
    send_frame(8'h00, 1'b0, bits, stf, len, w);
    chk("mid_after_bits", bits, 32'hA << (8 + PAR));
    chk("mid_after_stuff", stf, 32'd0);

    // Loopback: 1000 random payloads, one detector hit per frame at sync bit 4.
    a0 = det_all; g0 = det_good;
    for (int i = 0; i < 1000; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b0, bits, stf, len, w);
      chk($sformatf("rnd%0d_%02h_len", i, d), len, 12 + PAR + $countones(stf));
    end
    repeat (4) @(negedge clk);
    chk("loop_all_pulses", det_all - a0, 1000);
    chk("loop_sync_pulses", det_good - g0, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
